control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Parametrised multi-cycle sequencer that owns the CPU state register the decode control block consumes.
- It steps FETCH/EXEC/MEM/LOAD_DATA, holds bus strobes across Avalon-style waitrequest stalls, and sequences multi-cycle mult/div.
- It detects halt (jump to address 0) and has an optional bus-wait timeout.
- It sits between the bus interface and the datapath, and drives the PC, IR and commit strobes.

Parameters:
- MULT_CYCLES, 4, EXEC-to-commit latency of MULT/MULTU; must be >=1.
- DIV_CYCLES, 34, latency of DIV/DIVU; must be >=1.
- WAIT_LIMIT, 0, maximum consecutive waitrequest cycles in one bus state; 0 = unlimited.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES, WAIT_LIMIT).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock, asynchronous assert, active-low.
- opcode  in  6  instruction[31:26] from the IR.
- function_code  in  6  instruction[5:0] from the IR.
- waitrequest  in  1  bus stall.
- next_pc_zero  in  1  the PC value to be written this cycle is 0x00000000.
- state  out  3  0=FETCH, 2=MEM, 3=LOAD_DATA, 4=EXEC, 5=MULTDIV, 6=HALT.
- active  out  1  CPU running.
- read  out  1  bus read.
- write  out  1  bus write.
- ir_load  out  1  capture readdata into the IR.
- pc_wren  out  1  commit the next PC.
- reg_commit  out  1  register-file write strobe, gating the decode reg_write_enable.
- multdiv_start  out  1  one-cycle start pulse to the multiplier/divider.
- multdiv_busy  out  1  mult/div in progress.
- hilo_commit  out  1  write the multdiv result into HI/LO.
- bus_timeout  out  1  sticky error flag.

Behaviour:
- Reset (async, reset_n=0): state=FETCH, counters=0, bus_timeout=0, active=1. All strobes are 0 while reset is held. Reset mid-operation aborts immediately; no commit strobe fires.
- All outputs are combinational from the registered state, counter and inputs. Transitions occur on the clk rising edge.
- Load/store class: opcode 32-38 and 40,41,43. Store class: 40,41,43.
- Mult/div class: opcode 0 with function_code 24-27. DIV class: function_code 26,27.
- FETCH:
  - read=1 throughout.
  - If waitrequest=1: stay, and increment wait_cnt.
  - If waitrequest=0: ir_load=1, wait_cnt:=0, next=EXEC.
- EXEC:
  - Load/store class: next=MEM, no PC/reg strobes.
  - Mult/div class: multdiv_start=1 for this cycle. Counter loaded with DIV_CYCLES (DIV class) or MULT_CYCLES. next=MULTDIV.
  - Otherwise:
    - pc_wren=1, and reg_commit=1 except for opcode 0 with function 8,17,19.
    - next=HALT if next_pc_zero, else FETCH.
- MEM:
  - read=1 for loads; write=1 for stores. The strobes and address stay stable while waitrequest=1; wait_cnt counts.
  - If waitrequest=0, load: next=LOAD_DATA.
  - If waitrequest=0, store: pc_wren=1, next=FETCH (HALT if next_pc_zero).
- LOAD_DATA: reg_commit=1, pc_wren=1, next=FETCH (HALT if next_pc_zero). No bus strobes.
- MULTDIV:
  - multdiv_busy=1, counter decrements each cycle.
  - When counter==1: hilo_commit=1, pc_wren=1, next=FETCH/HALT.
  - Total cycles in MULTDIV = loaded latency.
- HALT: active=0, all strobes 0. Absorbing until reset.
- Timeout (WAIT_LIMIT>0):
  - If wait_cnt reaches WAIT_LIMIT while waitrequest is still 1 in FETCH or MEM: bus_timeout:=1 (sticky), next=HALT.
  - read/write deassert in the HALT cycle.
  - wait_cnt saturates and clears on every state change.
- With WAIT_LIMIT=0, wait_cnt never triggers HALT and saturates at all-ones.
- waitrequest is ignored outside FETCH/MEM.
- Only one of ir_load, reg_commit, hilo_commit, multdiv_start is asserted per cycle.
- read and write are never both 1.

Test Plan:
- Reset release, ADDU (op0/fn33), waitrequest=0 -> states 0,4,0; ir_load in cycle 1; pc_wren+reg_commit in cycle 2; 2 cycles per instruction.
- LW (op35), waitrequest high for 3 cycles in MEM -> read held 4 MEM cycles; then LOAD_DATA with reg_commit=1, pc_wren=1; back to FETCH.
- SW (op43) at MEM -> write=1, read=0; pc_wren on the waitrequest=0 cycle; no reg_commit.
- DIVU (fn27), DIV_CYCLES=34 -> multdiv_start 1 cycle in EXEC; multdiv_busy for 34 cycles; hilo_commit+pc_wren on the 34th; MULT under default parameters -> 4 cycles.
- JR with next_pc_zero=1 in EXEC -> state=6, active=0 next cycle; it stays there despite further waitrequest/opcode activity.
- WAIT_LIMIT=8, waitrequest stuck high in FETCH -> bus_timeout=1 and HALT after 8 wait cycles. reset_n low mid-MULTDIV -> state=0 asynchronously, hilo_commit never asserted, bus_timeout cleared.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Bus and control bundle between the control sequencer, the bus interface
// and the datapath. The sequencer drives the master side.
interface control_sequencer_if;
  logic [5:0] opcode;
  logic [5:0] function_code;
  logic       waitrequest;
  logic       next_pc_zero;
  logic [2:0] state;
  logic       active;
  logic       read;
  logic       write;
  logic       ir_load;
  logic       pc_wren;
  logic       reg_commit;
  logic       multdiv_start;
  logic       multdiv_busy;
  logic       hilo_commit;
  logic       bus_timeout;

  modport master (
    input  opcode, function_code, waitrequest, next_pc_zero,
    output state, active, read, write, ir_load, pc_wren, reg_commit,
           multdiv_start, multdiv_busy, hilo_commit, bus_timeout
  );

  modport slave (
    output opcode, function_code, waitrequest, next_pc_zero,
    input  state, active, read, write, ir_load, pc_wren, reg_commit,
           multdiv_start, multdiv_busy, hilo_commit, bus_timeout
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle CPU sequencer: FETCH/EXEC/MEM/LOAD_DATA/MULTDIV/HALT with
// waitrequest stall handling, mult/div latency counting and bus-wait timeout.
module control_sequencer #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 34,
  parameter int WAIT_LIMIT  = 0,
  parameter int CNT_W       = 6
) (
  input  logic                       clk,
  input  logic                       reset_n,
  control_sequencer_if.master        seq
);

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_MEM       = 3'd2,
    ST_LOAD_DATA = 3'd3,
    ST_EXEC      = 3'd4,
    ST_MULTDIV   = 3'd5,
    ST_HALT      = 3'd6
  } state_e;

  localparam int WL_M1 = (WAIT_LIMIT > 0) ? (WAIT_LIMIT - 1) : 0;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   md_cnt_q, md_cnt_d;
  logic               timeout_q, timeout_d;

  logic is_load_s, is_store_s, is_md_s, is_div_s, no_rc_s;
  logic timeout_hit_s;
  logic [CNT_W-1:0] wait_inc_s;
  state_e retire_s;
  logic rd_s, wr_s, ir_s, pc_s, rc_s, start_s, busy_s, hilo_s, active_s;

  // Instruction class decode from the IR fields
  always_comb begin
    is_load_s  = (seq.opcode >= 6'd32) && (seq.opcode <= 6'd38);
    is_store_s = (seq.opcode == 6'd40) || (seq.opcode == 6'd41) || (seq.opcode == 6'd43);
    is_md_s    = (seq.opcode == 6'd0) && (seq.function_code[5:2] == 4'b0110);
    is_div_s   = is_md_s && seq.function_code[1];
    no_rc_s    = (seq.opcode == 6'd0) &&
                 ((seq.function_code == 6'd8) || (seq.function_code == 6'd17) ||
                  (seq.function_code == 6'd19));
  end

  // Wait counter helpers: saturating increment and timeout detect
  always_comb begin
    if (&wait_cnt_q) begin
      wait_inc_s = wait_cnt_q;
    end else begin
      wait_inc_s = wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    timeout_hit_s = (WAIT_LIMIT != 0) && (wait_cnt_q >= CNT_W'(WL_M1));
    retire_s      = seq.next_pc_zero ? ST_HALT : ST_FETCH;
  end

  // Next-state and strobe decode; wait_cnt clears on any state change
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = {CNT_W{1'b0}};
    md_cnt_d   = md_cnt_q;
    timeout_d  = timeout_q;
    rd_s = 1'b0; wr_s = 1'b0; ir_s = 1'b0; pc_s = 1'b0; rc_s = 1'b0;
    start_s = 1'b0; busy_s = 1'b0; hilo_s = 1'b0; active_s = 1'b1;
    case (state_q)
      ST_FETCH: begin
        rd_s = 1'b1;
        if (seq.waitrequest) begin
          if (timeout_hit_s) begin
            timeout_d = 1'b1;
            state_d   = ST_HALT;
          end else begin
            wait_cnt_d = wait_inc_s;
          end
        end else begin
          ir_s    = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_load_s || is_store_s) begin
          state_d = ST_MEM;
        end else if (is_md_s) begin
          start_s  = 1'b1;
          md_cnt_d = is_div_s ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d  = ST_MULTDIV;
        end else begin
          pc_s    = 1'b1;
          rc_s    = ~no_rc_s;
          state_d = retire_s;
        end
      end
      ST_MEM: begin
        rd_s = ~is_store_s;
        wr_s = is_store_s;
        if (seq.waitrequest) begin
          if (timeout_hit_s) begin
            timeout_d = 1'b1;
            state_d   = ST_HALT;
          end else begin
            wait_cnt_d = wait_inc_s;
          end
        end else if (is_store_s) begin
          pc_s    = 1'b1;
          state_d = retire_s;
        end else begin
          state_d = ST_LOAD_DATA;
        end
      end
      ST_LOAD_DATA: begin
        rc_s    = 1'b1;
        pc_s    = 1'b1;
        state_d = retire_s;
      end
      ST_MULTDIV: begin
        busy_s = 1'b1;
        if (md_cnt_q <= CNT_W'(1)) begin
          hilo_s   = 1'b1;
          pc_s     = 1'b1;
          md_cnt_d = {CNT_W{1'b0}};
          state_d  = retire_s;
        end else begin
          md_cnt_d = md_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_HALT: begin
        active_s = 1'b0;
      end
      default: begin
        // Unreachable encodings park the CPU rather than run on garbage
        active_s = 1'b0;
        state_d  = ST_HALT;
      end
    endcase
  end

  // State, counter and sticky timeout registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= {CNT_W{1'b0}};
      md_cnt_q   <= {CNT_W{1'b0}};
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      md_cnt_q   <= md_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Strobes are forced low while reset is held so nothing commits mid-abort
  assign seq.state         = state_q;
  assign seq.active        = active_s;
  assign seq.bus_timeout   = timeout_q;
  assign seq.read          = rd_s    & reset_n;
  assign seq.write         = wr_s    & reset_n;
  assign seq.ir_load       = ir_s    & reset_n;
  assign seq.pc_wren       = pc_s    & reset_n;
  assign seq.reg_commit    = rc_s    & reset_n;
  assign seq.multdiv_start = start_s & reset_n;
  assign seq.multdiv_busy  = busy_s  & reset_n;
  assign seq.hilo_commit   = hilo_s  & reset_n;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-cycle expected output vectors
// are queued as stimulus is applied and popped when the outputs are sampled.
module tb_control_sequencer;

  localparam logic [9:0] F_ACT  = 10'b1000000000;
  localparam logic [9:0] F_RD   = 10'b0100000000;
  localparam logic [9:0] F_WR   = 10'b0010000000;
  localparam logic [9:0] F_IR   = 10'b0001000000;
  localparam logic [9:0] F_PC   = 10'b0000100000;
  localparam logic [9:0] F_RC   = 10'b0000010000;
  localparam logic [9:0] F_ST   = 10'b0000001000;
  localparam logic [9:0] F_BUSY = 10'b0000000100;
  localparam logic [9:0] F_HILO = 10'b0000000010;
  localparam logic [9:0] F_TO   = 10'b0000000001;
  localparam logic [9:0] F_NONE = 10'b0000000000;

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_MEM   = 3'd2;
  localparam logic [2:0] S_LD    = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_MD    = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        wr;
    logic        nz;
    logic [12:0] e;
  } cyc_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  logic [12:0] exp_q[$];

  control_sequencer_if seq();

  control_sequencer #(
    .MULT_CYCLES(4),
    .DIV_CYCLES(34),
    .WAIT_LIMIT(8),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .seq(seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cyc_t mk(input logic [5:0] op, input logic [5:0] fn,
                              input logic wr, input logic nz,
                              input logic [2:0] st, input logic [9:0] fl);
    cyc_t c;
    c.op = op; c.fn = fn; c.wr = wr; c.nz = nz; c.e = {st, fl};
    return c;
  endfunction

  function automatic logic [12:0] outs();
    return {seq.state, seq.active, seq.read, seq.write, seq.ir_load, seq.pc_wren,
            seq.reg_commit, seq.multdiv_start, seq.multdiv_busy, seq.hilo_commit,
            seq.bus_timeout};
  endfunction

  task automatic drive(input cyc_t c);
    seq.opcode        = c.op;
    seq.function_code = c.fn;
    seq.waitrequest   = c.wr;
    seq.next_pc_zero  = c.nz;
    exp_q.push_back(c.e);
  endtask

  task automatic test_reset();
    logic [12:0] e, got;
    reset_n = 1'b0;
    drive(mk(6'd0, 6'd33, 1'b1, 1'b0, S_FETCH, F_ACT));
    #2;
    e = exp_q.pop_front(); got = outs(); checks++;
    if (got !== e) begin failures++; $display("FAIL reset_held got=%h exp=%h", got, e); end
    @(negedge clk);
    drive(mk(6'd35, 6'd0, 1'b0, 1'b1, S_FETCH, F_ACT));
    #2;
    e = exp_q.pop_front(); got = outs(); checks++;
    if (got !== e) begin failures++; $display("FAIL reset_after_edge got=%h exp=%h", got, e); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_addu();
    cyc_t c[$];
    logic [12:0] e, got;
    c.push_back(mk(6'd0, 6'd33, 1'b0, 1'b0, S_FETCH, F_ACT | F_RD | F_IR));
    c.push_back(mk(6'd0, 6'd33, 1'b0, 1'b0, S_EXEC,  F_ACT | F_PC | F_RC));
    foreach (c[i]) begin
      drive(c[i]); #2;
      e = exp_q.pop_front(); got = outs(); checks++;
      if (got !== e) begin failures++; $display("FAIL addu cyc%0d got=%h exp=%h", i, got, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    cyc_t c[$];
    logic [12:0] e, got;
    c.push_back(mk(6'd0, 6'd33, 1'b1, 1'b0, S_FETCH, F_ACT | F_RD));
    c.push_back(mk(6'd0, 6'd33, 1'b0, 1'b0, S_FETCH, F_ACT | F_RD | F_IR));
    c.push_back(mk(6'd0, 6'd33, 1'b1, 1'b0, S_EXEC,  F_ACT | F_PC | F_RC));
    c.push_back(mk(6'd0, 6'd17, 1'b0, 1'b0, S_FETCH, F_ACT | F_RD | F_IR));
    c.push_back(mk(6'd0, 6'd17, 1'b0, 1'b0, S_EXEC,  F_ACT | F_PC));
    c.push_back(mk(6'd32, 6'd0, 1'b0, 1'b0, S_FETCH, F_ACT | F_RD | F_IR));
    c.push_back(mk(6'd32, 6'd0, 1'b0, 1'b0, S_EXEC,  F_ACT));
    c.push_back(mk(6'd32, 6'd0, 1'b0, 1'b0, S_MEM,   F_ACT | F_RD));
    c.push_back(mk(6'd32, 6'd0, 1'b1, 1'b0, S_LD,    F_ACT | F_PC | F_RC));
    foreach (c[i]) begin
      drive(c[i]); #2;
      e = exp_q.pop_front(); got = outs(); checks++;
      if (got !== e) begin failures++; $display("FAIL b2b cyc%0d got=%h exp=%h", i, got, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_lw_wait();
    cyc_t c[$];
    logic [12:0] e, got;
    c.push_back(mk(6'd35, 6'd0, 1'b0, 1'b0, S_FETCH, F_ACT | F_RD | F_IR));
    c.push_back(mk(6'd35, 6'd0, 1'b1, 1'b0, S_EXEC,  F_ACT));
    for (int k = 0; k < 3; k++)
      c.push_back(mk(6'd35, 6'd0, 1'b1, 1'b0, S_MEM, F_ACT | F_RD));
    c.push_back(mk(6'd35, 6'd0, 1'b0, 1'b0, S_MEM,   F_ACT | F_RD));
    c.push_back(mk(6'd35, 6'd0, 1'b0, 1'b0, S_LD,    F_ACT | F_PC | F_RC));
    foreach (c[i]) begin
      drive(c[i]); #2;
      e = exp_q.pop_front(); got = outs(); checks++;
      if (got !== e) begin failures++; $display("FAIL lw cyc%0d got=%h exp=%h", i, got, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_sw();
    cyc_t c[$];
    logic [12:0] e, got;
    c.push_back(mk(6'd43, 6'd0, 1'b0, 1'b0, S_FETCH, F_ACT | F_RD | F_IR));
    c.push_back(mk(6'd43, 6'd0, 1'b0, 1'b0, S_EXEC,  F_ACT));
    c.push_back(mk(6'd43, 6'd0, 1'b1, 1'b0, S_MEM,   F_ACT | F_WR));
    c.push_back(mk(6'd43, 6'd0, 1'b0, 1'b0, S_MEM,   F_ACT | F_WR | F_PC));
    foreach (c[i]) begin
      drive(c[i]); #2;
      e = exp_q.pop_front(); got = outs(); checks++;
      if (got !== e) begin failures++; $display("FAIL sw cyc%0d got=%h exp=%h", i, got, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_multdiv(input logic [5:0] fn, input int lat, input string nm);
    cyc_t c[$];
    logic [12:0] e, got;
    c.push_back(mk(6'd0, fn, 1'b0, 1'b0, S_FETCH, F_ACT | F_RD | F_IR));
    c.push_back(mk(6'd0, fn, 1'b1, 1'b0, S_EXEC,  F_ACT | F_ST));
    for (int k = 1; k < lat; k++)
      c.push_back(mk(6'd0, fn, k[0], 1'b0, S_MD, F_ACT | F_BUSY));
    c.push_back(mk(6'd0, fn, 1'b0, 1'b0, S_MD, F_ACT | F_BUSY | F_HILO | F_PC));
    foreach (c[i]) begin
      drive(c[i]); #2;
      e = exp_q.pop_front(); got = outs(); checks++;
      if (got !== e) begin failures++; $display("FAIL %s cyc%0d got=%h exp=%h", nm, i, got, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_jr_halt();
    cyc_t c[$];
    logic [12:0] e, got;
    c.push_back(mk(6'd0, 6'd8,  1'b0, 1'b0, S_FETCH, F_ACT | F_RD | F_IR));
    c.push_back(mk(6'd0, 6'd8,  1'b0, 1'b1, S_EXEC,  F_ACT | F_PC));
    c.push_back(mk(6'd35, 6'd0, 1'b1, 1'b0, S_HALT,  F_NONE));
    c.push_back(mk(6'd43, 6'd0, 1'b0, 1'b1, S_HALT,  F_NONE));
    c.push_back(mk(6'd0, 6'd27, 1'b0, 1'b0, S_HALT,  F_NONE));
    foreach (c[i]) begin
      drive(c[i]); #2;
      e = exp_q.pop_front(); got = outs(); checks++;
      if (got !== e) begin failures++; $display("FAIL jr_halt cyc%0d got=%h exp=%h", i, got, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    cyc_t c[$];
    logic [12:0] e, got;
    for (int k = 0; k < 8; k++)
      c.push_back(mk(6'd0, 6'd33, 1'b1, 1'b0, S_FETCH, F_ACT | F_RD));
    c.push_back(mk(6'd0, 6'd33, 1'b1, 1'b0, S_HALT, F_TO));
    c.push_back(mk(6'd0, 6'd33, 1'b0, 1'b0, S_HALT, F_TO));
    foreach (c[i]) begin
      drive(c[i]); #2;
      e = exp_q.pop_front(); got = outs(); checks++;
      if (got !== e) begin failures++; $display("FAIL timeout cyc%0d got=%h exp=%h", i, got, e); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_multdiv();
    cyc_t c[$];
    logic [12:0] e, got;
    c.push_back(mk(6'd0, 6'd26, 1'b0, 1'b0, S_FETCH, F_ACT | F_RD | F_IR));
    c.push_back(mk(6'd0, 6'd26, 1'b0, 1'b0, S_EXEC,  F_ACT | F_ST));
    for (int k = 0; k < 3; k++)
      c.push_back(mk(6'd0, 6'd26, 1'b0, 1'b0, S_MD, F_ACT | F_BUSY));
    foreach (c[i]) begin
      drive(c[i]); #2;
      e = exp_q.pop_front(); got = outs(); checks++;
      if (got !== e) begin failures++; $display("FAIL mdabort cyc%0d got=%h exp=%h", i, got, e); end
      @(negedge clk);
    end
    drive(mk(6'd0, 6'd26, 1'b0, 1'b0, S_FETCH, F_ACT));
    #2 reset_n = 1'b0;
    #1;
    e = exp_q.pop_front(); got = outs(); checks++;
    if (got !== e) begin failures++; $display("FAIL async_abort got=%h exp=%h", got, e); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    seq.opcode = 6'd0;
    seq.function_code = 6'd0;
    seq.waitrequest = 1'b0;
    seq.next_pc_zero = 1'b0;
    @(negedge clk);
    test_reset();
    test_addu();
    test_back_to_back();
    test_lw_wait();
    test_sw();
    test_multdiv(6'd24, 4, "mult");
    test_multdiv(6'd27, 34, "divu");
    test_jr_halt();
    test_reset();
    test_timeout();
    test_reset();
    test_reset_mid_multdiv();
    test_addu();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
